fighter_sprite_engine: RTL

FIGHTER_SPRITE_ENGINE -- requirements
Module: fighter_sprite_engine

---
 rtl/fighter_pkg.sv | 45 ++++
 rtl/sprite_rom.sv | 25 ++
 rtl/fighter_sprite_engine.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fighter_pkg.sv
// Shared types, tuning constants and per-animation sprite tables for the fighter sprite engine.
// sprite_byte() defines the built-in sprite image so the ROM and its users agree on contents.
package fighter_pkg;

  localparam int unsigned NUM_ANIM    = 6;
  localparam int unsigned SCALE_SHIFT = 1;
  localparam int unsigned FRAME_HOLD  = 4;
  localparam int unsigned X_INIT      = 50;
  localparam int unsigned Y_INIT      = 200;
  localparam int unsigned X_MIN       = 10;
  localparam int unsigned MOVE_STEP   = 1;
  localparam int unsigned KNOCKBACK   = 5;
  localparam int unsigned COLLIDE_W   = 50;
  localparam int unsigned ADDR_W      = 12;

  localparam logic [7:0] TRANSPARENT = 8'h00;

  typedef enum logic [2:0] {
    AnimStand  = 3'd0,
    AnimAttack = 3'd1,
    AnimMoveL  = 3'd2,
    AnimMoveR  = 3'd3,
    AnimHurt   = 3'd4,
    AnimDefend = 3'd5
  } anim_e;

  localparam int unsigned WIDTH  [NUM_ANIM] = '{21, 28, 21, 21, 21, 21};
  localparam int unsigned HEIGHT [NUM_ANIM] = '{30, 30, 30, 30, 30, 30};
  localparam int unsigned FRAMES [NUM_ANIM] = '{4, 3, 4, 4, 2, 2};
  localparam bit          LOOP   [NUM_ANIM] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  function automatic int unsigned rom_depth(int unsigned anim);
    return FRAMES[anim] * WIDTH[anim] * HEIGHT[anim];
  endfunction

  // Every fifth byte is see-through; the rest encode the animation and low address bits.
  function automatic logic [7:0] sprite_byte(logic [2:0] anim, logic [ADDR_W-1:0] addr,
                                             int unsigned depth, logic [7:0] salt);
    if (32'(addr) >= depth || (addr % 12'd5) == 12'd0) begin
      return TRANSPARENT;
    end
    return {anim, addr[4:0]} ^ salt;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// One animation's sprite sheet: 8-bit palette indices with a registered read port.
module sprite_rom
  import fighter_pkg::*;
#(
  parameter int unsigned DEPTH     = 1,
  parameter string       INIT_FILE = "",
  parameter int unsigned ANIM      = 0
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [7:0]        data_o
);

  // A named image gets a distinct salt so it never aliases the default sheet.
  localparam logic [7:0] Salt = (INIT_FILE == "") ? 8'h00 : 8'hA5;

  logic [7:0] data_q;

  always_ff @(posedge clk_i) begin
    data_q <= sprite_byte(3'(ANIM), addr_i, DEPTH, Salt);
  end

  assign data_o = data_q;

endmodule

// File: rtl/fighter_sprite_engine.sv
// Fighter character: frame-tick driven animation and movement with opponent/wall clamping,
// plus a one-cycle-latency pixel pipeline that looks up the current sprite frame.
module fighter_sprite_engine
  import fighter_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [2:0] anim_state,
  input  logic       move_l,
  input  logic       move_r,
  input  logic       facing_left,
  input  logic [9:0] opponent_x,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       is_character,
  output logic [7:0] data_Out,
  output logic [9:0] character_x,
  output logic [3:0] frame_idx,
  output logic       anim_done
);

  logic        fclk_q, armed_q, tick;
  anim_e       anim_q, anim_d, req;
  logic [3:0]  frame_q, frame_d, hold_q, hold_d;
  logic        ended_q, ended_d, done_q, done_d;
  logic [9:0]  x_q, x_d;
  logic signed [11:0] xs, opp_s;

  // armed_q keeps a frame_clk that is already high when reset lifts from counting as an edge.
  assign tick = armed_q & frame_clk & ~fclk_q;

  always_comb begin
    req     = (anim_state >= 3'(NUM_ANIM)) ? AnimStand : anim_e'(anim_state);
    anim_d  = anim_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    ended_d = ended_q;
    done_d  = 1'b0;
    if (tick) begin
      if (req != anim_q) begin
        anim_d  = req;
        frame_d = 4'd0;
        hold_d  = 4'd0;
        ended_d = 1'b0;
      end else if (hold_q == 4'(FRAME_HOLD - 1)) begin
        hold_d = 4'd0;
        if (frame_q == 4'(FRAMES[anim_q] - 1)) begin
          if (LOOP[anim_q]) begin
            frame_d = 4'd0;
          end else if (!ended_q) begin
            done_d  = 1'b1;
            ended_d = 1'b1;
          end
        end else begin
          frame_d = frame_q + 4'd1;
        end
      end else begin
        hold_d = hold_q + 4'd1;
      end
    end
  end

  always_comb begin
    xs    = $signed({2'b00, x_q});
    opp_s = $signed({2'b00, opponent_x});
    x_d   = x_q;
    if (tick) begin
      if (req == AnimHurt) begin
        xs = xs - $signed(12'(KNOCKBACK));
      end else if (move_l && move_r) begin
        xs = xs;
      end else if (move_r) begin
        xs = xs + $signed(12'(MOVE_STEP));
      end else if (move_l) begin
        xs = xs - $signed(12'(MOVE_STEP));
      end
      if (xs + $signed(12'(COLLIDE_W)) > opp_s) begin
        xs = opp_s - $signed(12'(COLLIDE_W));
      end
      if (xs < $signed(12'(X_MIN))) begin
        xs = $signed(12'(X_MIN));
      end
      x_d = 10'(xs);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fclk_q  <= 1'b0;
      armed_q <= 1'b0;
      anim_q  <= AnimStand;
      frame_q <= 4'd0;
      hold_q  <= 4'd0;
      ended_q <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= 10'(X_INIT);
    end else begin
      fclk_q  <= frame_clk;
      armed_q <= 1'b1;
      anim_q  <= anim_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      ended_q <= ended_d;
      done_q  <= done_d;
      x_q     <= x_d;
    end
  end

  // Pixel stage 0: box test and sprite address for the current pixel.
  logic [11:0]       px, py, x_ext, w_px, h_px, rx, ry;
  logic [15:0]       addr_wide;
  logic [ADDR_W-1:0] rom_addr;
  logic              in_box;

  always_comb begin
    px    = {2'b00, DrawX};
    py    = {2'b00, DrawY};
    x_ext = {2'b00, x_q};
    w_px  = 12'(WIDTH[anim_q]) << SCALE_SHIFT;
    h_px  = 12'(HEIGHT[anim_q]) << SCALE_SHIFT;
    in_box = (px >= x_ext) && (px < x_ext + w_px) &&
             (py >= 12'(Y_INIT)) && (py < 12'(Y_INIT) + h_px);
    rx = (px - x_ext) >> SCALE_SHIFT;
    ry = (py - 12'(Y_INIT)) >> SCALE_SHIFT;
    if (facing_left) begin
      rx = 12'(WIDTH[anim_q]) - 12'd1 - rx;
    end
    addr_wide = 16'(frame_q) * 16'(WIDTH[anim_q] * HEIGHT[anim_q]) +
                16'(ry) * 16'(WIDTH[anim_q]) + 16'(rx);
    rom_addr  = ADDR_W'(addr_wide);
  end

  logic [7:0] rom_data [NUM_ANIM];

  for (genvar g = 0; g < NUM_ANIM; g++) begin : g_rom
    sprite_rom #(
      .DEPTH    (rom_depth(g)),
      .INIT_FILE(""),
      .ANIM     (g)
    ) u_rom (
      .clk_i (Clk),
      .addr_i(rom_addr),
      .data_o(rom_data[g])
    );
  end

  // Stage 1: box flag and animation select travel alongside the registered ROM read.
  logic  inbox_q;
  anim_e anim_p_q;
  logic [7:0] rom_sel;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      inbox_q  <= 1'b0;
      anim_p_q <= AnimStand;
    end else begin
      inbox_q  <= in_box;
      anim_p_q <= anim_q;
    end
  end

  assign rom_sel      = rom_data[anim_p_q];
  assign data_Out     = inbox_q ? rom_sel : 8'h00;
  assign is_character = inbox_q && (rom_sel != TRANSPARENT);
  assign character_x  = x_q;
  assign frame_idx    = frame_q;
  assign anim_done    = done_q;

endmodule
